pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decoder.sv | 72 +++++++
 rtl/pipe_ctrl_unit.sv | 103 ++++++++++
 tb/tb_pipe_ctrl_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode and ALU-op constants plus the control bundles carried down the pipe.
package ctrl_pkg;
  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int ALU_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_R   = 3'd2;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd3;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd4;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic [ALU_W-1:0] alu_op;
    logic             branch;
    logic             branch_ne;
    logic             jump;
  } ctrl_t;

  typedef struct packed {
    logic             alu_src;
    logic             reg_dst;
    logic [ALU_W-1:0] alu_op;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } memwb_t;
endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder; EXT_OPS enables andi/ori/bne.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int EXT_OPS = 0
) (
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           ctrl_o,
  output logic            illegal_o
);
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALU_R;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_ANDI: begin
        if (EXT_OPS != 0) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = ALU_AND;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_ORI: begin
        if (EXT_OPS != 0) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = ALU_OR;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_BNE: begin
        if (EXT_OPS != 0) begin
          ctrl_o.branch    = 1'b1;
          ctrl_o.branch_ne = 1'b1;
          ctrl_o.alu_op    = ALU_SUB;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode in ID, carry controls through ID/EX, EX/MEM, MEM/WB,
// with load-use stall, freeze and flush handling.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int EXT_OPS = 0,
  localparam int ALUOP_W = (EXT_OPS != 0) ? 3 : 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [REG_W-1:0]   RsID_i,
  input  logic [REG_W-1:0]   RtID_i,
  input  logic               Flush_i,
  input  logic               Freeze_i,
  output logic               PCWrite_o,
  output logic               IFIDWrite_o,
  output logic               IFIDFlush_o,
  output logic               Branch_o,
  output logic               BranchNe_o,
  output logic               Jump_o,
  output logic               ALUSrc_o,
  output logic               RegDst_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               Illegal_o
);
  ctrl_t  id_ctrl;
  idex_t  idex_q, idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   hazard;
  logic   stall;
  logic   unused_alu_hi;

  ctrl_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
    .op_i      (Op_i),
    .ctrl_o    (id_ctrl),
    .illegal_o (Illegal_o)
  );

  assign hazard = idex_q.mem_read && (idex_q.rt != '0) &&
                  ((idex_q.rt == RsID_i) || (idex_q.rt == RtID_i));
  assign stall  = hazard || Freeze_i;

  // Reset forces the fetch enables high so the first cycle out of reset advances.
  assign PCWrite_o   = !rst_n_i || !stall;
  assign IFIDWrite_o = !rst_n_i || !stall;
  assign IFIDFlush_o = Flush_i && !stall;
  assign Branch_o    = id_ctrl.branch && !stall;
  assign BranchNe_o  = id_ctrl.branch_ne && !stall;
  assign Jump_o      = id_ctrl.jump && !stall;

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!Freeze_i) begin
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      if (hazard) begin
        idex_d = '0;
      end else begin
        idex_d.alu_src    = id_ctrl.alu_src;
        idex_d.reg_dst    = id_ctrl.reg_dst;
        idex_d.alu_op     = id_ctrl.alu_op;
        idex_d.mem_read   = id_ctrl.mem_read;
        idex_d.mem_write  = id_ctrl.mem_write;
        idex_d.reg_write  = id_ctrl.reg_write;
        idex_d.mem_to_reg = id_ctrl.mem_to_reg;
        idex_d.rt         = RtID_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ALUSrc_o      = idex_q.alu_src;
  assign RegDst_o      = idex_q.reg_dst;
  assign ALUOp_o       = idex_q.alu_op[ALUOP_W-1:0];
  assign MemRead_o     = exmem_q.mem_read;
  assign MemWrite_o    = exmem_q.mem_write;
  assign RegWrite_o    = memwb_q.reg_write;
  assign MemtoReg_o    = memwb_q.mem_to_reg;
  assign unused_alu_hi = idex_q.alu_op[ALU_W-1];
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: both EXT_OPS variants share one stimulus stream,
// expected outputs are queued per cycle and checked by an independent monitor.
module tb_pipe_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       flush, freeze;

  logic       pcw0, ifw0, ifl0, br0, bne0, j0, asrc0, rdst0, mr0, mw0, rw0, m2r0, ill0;
  logic [1:0] aop0;
  logic       pcw1, ifw1, ifl1, br1, bne1, j1, asrc1, rdst1, mr1, mw1, rw1, m2r1, ill1;
  logic [2:0] aop1;

  typedef struct {
    logic [14:0] e0;
    logic [6:0]  e1;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_id = 0;
  event chk_ev;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.EXT_OPS(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .RsID_i(rs), .RtID_i(rt),
    .Flush_i(flush), .Freeze_i(freeze),
    .PCWrite_o(pcw0), .IFIDWrite_o(ifw0), .IFIDFlush_o(ifl0), .Branch_o(br0),
    .BranchNe_o(bne0), .Jump_o(j0), .ALUSrc_o(asrc0), .RegDst_o(rdst0),
    .ALUOp_o(aop0), .MemRead_o(mr0), .MemWrite_o(mw0), .RegWrite_o(rw0),
    .MemtoReg_o(m2r0), .Illegal_o(ill0)
  );

  pipe_ctrl_unit #(.EXT_OPS(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .RsID_i(rs), .RtID_i(rt),
    .Flush_i(flush), .Freeze_i(freeze),
    .PCWrite_o(pcw1), .IFIDWrite_o(ifw1), .IFIDFlush_o(ifl1), .Branch_o(br1),
    .BranchNe_o(bne1), .Jump_o(j1), .ALUSrc_o(asrc1), .RegDst_o(rdst1),
    .ALUOp_o(aop1), .MemRead_o(mr1), .MemWrite_o(mw1), .RegWrite_o(rw1),
    .MemtoReg_o(m2r1), .Illegal_o(ill1)
  );

  // e0 = {PC,IFW,FL,BR,BNE,J, ASRC,RDST,AOP[1:0], MR,MW, RW,M2R, ILL}
  wire [14:0] got0 = {pcw0, ifw0, ifl0, br0, bne0, j0, asrc0, rdst0, aop0,
                      mr0, mw0, rw0, m2r0, ill0};
  // e1 = {AOP[2:0], ASRC, ILL, BNE, BR}
  wire [6:0]  got1 = {aop1, asrc1, ill1, bne1, br1};

  task automatic push_exp(input logic [14:0] e0, input logic [6:0] e1);
    exp_t x;
    x.e0 = e0;
    x.e1 = e1;
    x.id = vec_id;
    vec_id++;
    q.push_back(x);
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic f, input logic z,
                      input logic [14:0] e0, input logic [6:0] e1);
    @(posedge clk);
    #1;
    rst_n  = r;
    op     = o;
    rs     = s;
    rt     = t;
    flush  = f;
    freeze = z;
    push_exp(e0, e1);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (got0 === x.e0) passes++;
        else $display("FAIL vec%0d ext0 outputs: got %b required %b", x.id, got0, x.e0);
        checks++;
        if (got1 === x.e1) passes++;
        else $display("FAIL vec%0d ext1 outputs: got %b required %b", x.id, got1, x.e1);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; op = 6'h3f; rs = '0; rt = '0; flush = 1'b0; freeze = 1'b1;
    //    rst op     rs  rt  fl fr  e0                      e1
    step(0, 6'h3f, 0,  0,  0, 1, 15'b110000_0000_00_00_1, 7'b000_0100); // reset, freeze ignored
    step(1, 6'h23, 1,  7,  0, 0, 15'b110000_0000_00_00_0, 7'b000_0000); // lw rt=7
    step(1, 6'h08, 2,  3,  0, 0, 15'b110000_1000_00_00_0, 7'b000_1000); // addi
    step(1, 6'h3f, 0,  0,  0, 0, 15'b110000_1000_10_00_1, 7'b000_1100);
    step(1, 6'h23, 0,  5,  0, 0, 15'b110000_0000_00_11_0, 7'b000_0000); // lw in WB; lw rt=5
    step(1, 6'h00, 5,  9,  0, 0, 15'b000000_1000_00_10_0, 7'b000_1000); // load-use stall
    step(1, 6'h00, 5,  9,  0, 0, 15'b110000_0000_10_00_0, 7'b000_0000); // bubble in EX
    step(1, 6'h23, 0,  0,  0, 0, 15'b110000_0110_00_11_0, 7'b010_0000); // R in EX; lw rt=0
    step(1, 6'h2b, 0,  0,  0, 0, 15'b110000_1000_00_00_0, 7'b000_1000); // rt=0: no stall
    step(1, 6'h04, 1,  2,  1, 0, 15'b111100_1000_10_10_0, 7'b000_1001); // beq + flush
    step(1, 6'h04, 1,  2,  1, 1, 15'b000000_0001_01_11_0, 7'b001_0000); // freeze
    step(1, 6'h02, 0,  0,  1, 1, 15'b000000_0001_01_11_0, 7'b001_0000); // stages held
    step(1, 6'h02, 0,  0,  1, 0, 15'b111001_0001_01_11_0, 7'b001_0000); // j + flush
    step(1, 6'h0d, 0,  0,  0, 0, 15'b110000_0000_00_00_1, 7'b000_0000); // ori
    step(1, 6'h05, 3,  4,  0, 0, 15'b110000_0000_00_00_1, 7'b100_1011); // bne; ori in EX
    step(1, 6'h0c, 0,  0,  0, 0, 15'b110000_0000_00_00_1, 7'b001_0000); // andi; bne in EX
    step(1, 6'h23, 1,  6,  0, 0, 15'b110000_0000_00_00_0, 7'b011_1000); // lw rt=6; andi in EX
    step(1, 6'h04, 2,  6,  1, 0, 15'b000000_1000_00_00_0, 7'b000_1000); // stall masks beq/flush
    step(1, 6'h04, 2,  6,  1, 0, 15'b111100_0000_10_00_0, 7'b000_0001);
    // Asynchronous reset between edges while a lw sits in EX/MEM.
    @(negedge clk);
    #2;
    rst_n = 1'b0; op = 6'h3f; rs = '0; rt = '0; flush = 1'b0; freeze = 1'b1;
    #1;
    push_exp(15'b110000_0000_00_00_1, 7'b000_0100);
    ->chk_ev;
    step(0, 6'h3f, 0,  0,  0, 1, 15'b110000_0000_00_00_1, 7'b000_0100);
    step(1, 6'h08, 0,  0,  0, 0, 15'b110000_0000_00_00_0, 7'b000_0000); // first normal cycle
    step(1, 6'h3f, 0,  0,  0, 0, 15'b110000_1000_00_00_1, 7'b000_1100);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: pending expectations got %0d required 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
